// File: rtl/config_readback_pkg.sv
// Shared config index constants, FSM state encoding and response-byte helpers
// for the config readback path.
package config_readback_pkg;

  localparam logic [3:0] IDX_MODE       = 4'h0;
  localparam logic [3:0] IDX_BRIGHTNESS = 4'h1;
  localparam logic [3:0] IDX_ANIM       = 4'h4;
  localparam logic [3:0] IDX_DUMP       = 4'hF;
  localparam logic [3:0] NACK_NIBBLE    = 4'hE;

  localparam logic [1:0] DUMP_LAST = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } cfg_state_e;

  // Config index carried by each frame of a dump, in transmit order.
  function automatic logic [3:0] dump_index(input logic [1:0] n);
    case (n)
      2'd0:    dump_index = IDX_MODE;
      2'd1:    dump_index = IDX_BRIGHTNESS;
      default: dump_index = IDX_ANIM;
    endcase
  endfunction

  // Response byte doubles as a config write command restoring the value.
  function automatic logic [7:0] resp_byte(input logic [3:0] idx,
                                           input logic [3:0] mode_v,
                                           input logic [3:0] bright_v,
                                           input logic [3:0] anim_v);
    case (idx)
      IDX_MODE:       resp_byte = {idx, mode_v};
      IDX_BRIGHTNESS: resp_byte = {idx, bright_v};
      IDX_ANIM:       resp_byte = {idx, anim_v};
      default:        resp_byte = {NACK_NIBBLE, idx};
    endcase
  endfunction

endpackage

// File: rtl/config_readback_uart_tx_core.sv
// 8N1 UART transmitter: loads a byte on start, sends START/DATA/STOP and can
// chain directly into another LOAD when more frames are pending.
module uart_tx_core
  import config_readback_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       more,
  output logic       busy,
  output logic       frame_done,
  output logic       tx
);

  localparam int unsigned           BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  cfg_state_e        state_q, state_d;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              line;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  assign busy      = (state_q != IDLE);
  assign tx        = tx_q;

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    line       = 1'b1;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  state_d = START;
      START: begin
        line = 1'b0;
        if (baud_last) state_d = DATA;
      end
      DATA: begin
        line = shift_q[0];
        if (baud_last && (bit_q == 3'd7)) state_d = STOP;
      end
      STOP: begin
        if (baud_last) begin
          frame_done = 1'b1;
          state_d    = more ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the state by
  // one cycle; the caller's ready logic accounts for that lag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= line;
      case (state_q)
        LOAD: begin
          shift_q <= data;
          baud_q  <= '0;
          bit_q   <= '0;
        end
        START, DATA, STOP: begin
          baud_q <= baud_last ? '0 : baud_q + 1'b1;
          if ((state_q == DATA) && baud_last) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
          end
        end
        default: baud_q <= '0;
      endcase
    end
  end

endmodule

// File: rtl/config_readback.sv
// Config register readback over UART: accepts an index request, snapshots the
// live registers and returns one byte (or three for a dump).
module config_readback
  import config_readback_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_index,
  output logic       req_ready,
  input  logic [3:0] mode,
  input  logic [3:0] brightness,
  input  logic [3:0] animation_sel,
  output logic       tx
);

  logic       req_ready_q;
  logic [3:0] snap_idx_q;
  logic [3:0] snap_mode_q;
  logic [3:0] snap_bright_q;
  logic [3:0] snap_anim_q;
  logic       is_dump_q;
  logic [1:0] dump_cnt_q;

  logic       accept;
  logic       core_busy;
  logic       frame_done;
  logic       more;
  logic [3:0] sel_idx;
  logic [7:0] frame_byte;

  assign accept    = req_valid && req_ready_q;
  assign req_ready = req_ready_q;
  assign more      = is_dump_q && (dump_cnt_q != DUMP_LAST);
  assign sel_idx   = is_dump_q ? dump_index(dump_cnt_q) : snap_idx_q;
  assign frame_byte = resp_byte(sel_idx, snap_mode_q, snap_bright_q, snap_anim_q);

  // Ready returns one cycle after the core goes idle, which is the edge that
  // ends the stop bit on the registered tx line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready_q   <= 1'b1;
      snap_idx_q    <= '0;
      snap_mode_q   <= '0;
      snap_bright_q <= '0;
      snap_anim_q   <= '0;
      is_dump_q     <= 1'b0;
      dump_cnt_q    <= '0;
    end else if (accept) begin
      req_ready_q   <= 1'b0;
      snap_idx_q    <= req_index;
      snap_mode_q   <= mode;
      snap_bright_q <= brightness;
      snap_anim_q   <= animation_sel;
      is_dump_q     <= (req_index == IDX_DUMP);
      dump_cnt_q    <= '0;
    end else begin
      if (!core_busy) req_ready_q <= 1'b1;
      if (frame_done) dump_cnt_q <= dump_cnt_q + 2'd1;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .data      (frame_byte),
    .more      (more),
    .busy      (core_busy),
    .frame_done(frame_done),
    .tx        (tx)
  );

endmodule
